// File: rtl/alu_bist_seq.sv
// BIST pattern sequencer and MISR response checker for the ALU.
// Optional abort input is enabled by defining ALU_BIST_ABORT_EN.
module alu_bist_seq #(
    parameter int unsigned               DATA_W        = 8,
    parameter int unsigned               OP_W          = 3,
    parameter int unsigned               NUM_PATTERNS  = 256,
    parameter logic [2*DATA_W-1:0]       LFSR_SEED     = 16'hACE1,
    parameter logic [2*DATA_W-1:0]       LFSR_POLY     = 16'hB400,
    parameter logic [DATA_W-1:0]         MISR_POLY     = 8'hB8,
    parameter logic [DATA_W-1:0]         GOLDEN_SIG    = 8'h00,
    parameter int unsigned               DRAIN_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bist_start,
`ifdef ALU_BIST_ABORT_EN
    input  logic              bist_abort,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_result_valid,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic              bist_fail,
    output logic [DATA_W-1:0] signature
);

    localparam int unsigned LW    = 2 * DATA_W;
    localparam int unsigned TMO_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [15:0]      NUM_P    = 16'(NUM_PATTERNS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_DRAIN, S_COMPARE, S_DONE
    } state_t;

    state_t            state;
    logic              start_prev;
    logic              start_edge;
    logic [LW-1:0]     lfsr;
    logic [OP_W-1:0]   op;
    logic [15:0]       issue_cnt;
    logic [15:0]       recv_cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
    endfunction

    function automatic logic [DATA_W-1:0] misr_step(input logic [DATA_W-1:0] s,
                                                     input logic [DATA_W-1:0] r);
        return ({s[DATA_W-2:0], 1'b0} ^ (s[DATA_W-1] ? MISR_POLY : '0)) ^ r;
    endfunction

    assign start_edge = bist_start & ~start_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            start_prev <= 1'b0;
            lfsr       <= '0;
            op         <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            tmo_cnt    <= '0;
            signature  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_valid  <= 1'b0;
            bist_busy  <= 1'b0;
            bist_done  <= 1'b0;
            bist_pass  <= 1'b0;
            bist_fail  <= 1'b0;
        end else begin
            start_prev <= bist_start;

            // Compaction stops at NUM_PATTERNS so late or stray results cannot disturb the signature.
            if ((state == S_RUN || state == S_DRAIN) && alu_result_valid && recv_cnt < NUM_P) begin
                signature <= misr_step(signature, alu_result);
                recv_cnt  <= recv_cnt + 16'd1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        state     <= S_INIT;
                        lfsr      <= LFSR_SEED;
                        op        <= '0;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        signature <= '0;
                        bist_busy <= 1'b1;
                        bist_done <= 1'b0;
                        bist_pass <= 1'b0;
                        bist_fail <= 1'b0;
                    end
                end
                S_INIT, S_RUN: begin
                    if (state == S_RUN && issue_cnt == NUM_P) begin
                        state     <= S_DRAIN;
                        alu_valid <= 1'b0;
                        tmo_cnt   <= '0;
                    end else begin
                        // Vector for the next cycle is registered here, so RUN lasts NUM_PATTERNS cycles.
                        state     <= S_RUN;
                        alu_valid <= 1'b1;
                        alu_a     <= lfsr[LW-1:DATA_W];
                        alu_b     <= lfsr[DATA_W-1:0];
                        alu_op    <= op;
                        lfsr      <= lfsr_step(lfsr);
                        op        <= op + 1'b1;
                        issue_cnt <= issue_cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (recv_cnt == NUM_P) begin
                        state <= S_COMPARE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= S_DONE;
                        bist_busy <= 1'b0;
                        bist_done <= 1'b1;
                        bist_pass <= 1'b0;
                        bist_fail <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_COMPARE: begin
                    state     <= S_DONE;
                    bist_busy <= 1'b0;
                    bist_done <= 1'b1;
                    bist_pass <= (signature == GOLDEN_SIG);
                    bist_fail <= (signature != GOLDEN_SIG);
                end
                default: state <= S_IDLE;
            endcase

`ifdef ALU_BIST_ABORT_EN
            if (bist_abort && (state == S_INIT || state == S_RUN ||
                               state == S_DRAIN || state == S_COMPARE)) begin
                state     <= S_DONE;
                alu_valid <= 1'b0;
                bist_busy <= 1'b0;
                bist_done <= 1'b1;
                bist_pass <= 1'b0;
                bist_fail <= 1'b1;
            end
`endif
        end
    end

endmodule
